// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM status and arbiter state types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGNT, DGNT, STOP} arb_state_t;
    localparam int STARVE_LIMIT = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of dcache grants taken over a pending icache request.
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign sat = cnt == W'(LIMIT);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt <= '0;
        else cnt <= clr ? '0 : (inc && !sat) ? cnt + W'(1) : cnt;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: dcache-priority grant FSM onto the single-ported RAM, with bounded icache starvation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = cpu_types_pkg::STARVE_LIMIT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    input  logic      flushed,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      stopped
);
    arb_state_t state, nxt;
    logic dreq, sat, inc, clr, ig, dg, acc, done;
    assign dreq = dREN | dWEN;
    assign ig   = state == IGNT;
    assign dg   = state == DGNT;
    assign acc  = ramstate == ACCESS;
    // ACCESS or ERROR both end the grant; ERROR just leaves wait high so the request re-arbitrates
    assign done = acc || ramstate == ERROR;
    always_comb begin
        nxt = state == IDLE ? ((dreq && (!iREN || !sat)) ? DGNT : iREN ? IGNT : (halt && flushed) ? STOP : IDLE)
            : state == IGNT ? ((!iREN || done) ? IDLE : IGNT)
            : state == DGNT ? ((!dreq || done) ? IDLE : DGNT)
            : STOP;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else state <= nxt;
    end
    assign inc = state == IDLE && nxt == DGNT && iREN;
    assign clr = state == IDLE && (nxt == IGNT || !iREN);
    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .CLK(CLK), .nRST(nRST), .inc(inc), .clr(clr), .sat(sat)
    );
    assign ramREN   = ig || (dg && !dWEN);
    assign ramWEN   = dg && dWEN;
    assign ramaddr  = ig ? iaddr : dg ? daddr : '0;
    assign ramstore = (dg && dWEN) ? dstore : '0;
    assign iload    = (ig && acc) ? ramload : '0;
    assign dload    = (dg && acc) ? ramload : '0;
    assign iwait    = iREN && !(ig && acc);
    assign dwait    = dreq && !(dg && acc);
    assign stopped  = state == STOP;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the instruction-fetch and data-access request streams coming out of the cache layer onto the single-ported RAM. It sits between the icache/dcache pair and the RAM model. A registered grant FSM gives the dcache priority, with a bounded-starvation guarantee for the icache. After the datapath halts and the dcache reports flushed, the FSM parks in a terminal stopped state.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive dcache grants issued while an icache request is pending.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32 (word_t)  icache address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32 (word_t)  dcache address.
- dstore  in  32 (word_t)  dcache write data.
- halt  in  1  datapath halt.
- flushed  in  1  dcache flush complete.
- ramload  in  32 (word_t)  RAM read data.
- ramstate  in  2 (ramstate_t)  RAM status: FREE, BUSY, ACCESS, ERROR.
- iwait  out  1  icache stall.
- dwait  out  1  dcache stall.
- iload  out  32  read data to the icache.
- dload  out  32  read data to the dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- stopped  out  1  FSM is in STOP.

## Operation
- States: IDLE, IGNT, DGNT, STOP. The state register is reset to IDLE.
- Define dreq = dREN | dWEN.
- IDLE decision order:
  - If dreq and (!iREN or scnt < STARVE_LIMIT): go to DGNT.
  - Else if iREN: go to IGNT.
  - Else if halt & flushed: go to STOP.
  - Else: stay in IDLE.
- IGNT:
  - Drive ramREN=1, ramaddr=iaddr.
  - On ramstate==ACCESS: iwait=0 for that cycle, iload=ramload, go to IDLE.
  - If iREN drops: abort to IDLE, with no completion pulse.
- DGNT:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. dWEN wins when both dREN and dWEN are high.
  - Else: ramREN=1.
  - On ACCESS: dwait=0, dload=ramload, go to IDLE.
  - If dreq drops: abort to IDLE.
- ERROR in IGNT or DGNT: return to IDLE with wait still high. The request is re-arbitrated.
- Starvation counter scnt:
  - Increments on each IDLE→DGNT transition taken while iREN is high.
  - Clears on IDLE→IGNT, and on any IDLE cycle with iREN low.
  - Saturates at STARVE_LIMIT.
  - Reset value 0.
- STOP:
  - Absorbing until nRST.
  - ramREN=ramWEN=0, stopped=1.
  - iwait=iREN, dwait=dreq.
- Wait outputs in every state: xwait = xreq & !(granted to x & ramstate==ACCESS).
- All other outputs are 0 when not granted: ramaddr, ramstore, iload, dload, ramREN, ramWEN.

## Timing
- Reset (nRST low): state=IDLE, scnt=0, stopped=0, ramREN=ramWEN=0, ramaddr=ramstore=iload=dload=0. iwait and dwait follow their requests, so they are 0 when no request is present.
- Grant latency: a request sampled in IDLE at edge N asserts RAM enables in cycle N+1.
- Minimum transaction is 2 cycles: decision cycle plus an ACCESS cycle.
- One mandatory IDLE cycle separates back-to-back grants. This gives a 1-cycle re-arbitration bubble.
- RAM enables, address and store data are combinational from the granted requester's inputs. Requesters hold their inputs stable until wait is low.
- A simultaneous first request from both sides goes to dcache, because scnt starts at 0.
- halt & flushed with a request still pending: requests win; STOP is entered only from an idle IDLE.
- nRST asserted mid-transaction: outputs clear immediately (asynchronously). The interrupted RAM access is abandoned.

## Structure
- The state enum arb_state_t and the STARVE_LIMIT default belong in cpu_types_pkg, alongside word_t and ramstate_t.
- One sub-module, arb_starve_cnt: a saturating counter with inc, clr, sat output, and the same CLK/nRST.
- The top level contains the FSM plus combinational output muxing.

## Test plan
- Reset: assert nRST=0 mid-DGNT → all RAM outputs become 0 in the same cycle; state IDLE after release, stopped=0.
- Lone icache read: iREN=1, iaddr=0x40, ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 from cycle 1; iwait falls only in the ACCESS cycle; iload=0xDEADBEEF.
- Contention, STARVE_LIMIT=4: iREN held high with 6 back-to-back dcache requests → exactly 4 DGNT, then IGNT, then DGNT resumes.
- Simultaneous dREN=dWEN=1, daddr=0x80, dstore=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234.
- Abort/error: drop iREN mid-IGNT → IDLE next cycle, no iwait low pulse. Inject ERROR during DGNT → re-granted after an IDLE cycle.
- Halt: halt=1, flushed=1, no requests → stopped=1 next cycle. Then iREN=1 → iwait=1 and ramREN=0 indefinitely until reset.
